sdram_client_arb: RTL and testbench
===================================

SDRAM_CLIENT_ARB -- requirements
Module: sdram_client_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, meaning the SDRAM byte-address width driven on sdr_addr.
REQ-002 SHALL have parameter SCN_BURST, default 2, meaning the number of 16-bit words fetched per tile-ROM request (legal values 1 and 2).
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_addr  in  32  CPU byte address; cpu_data  in  16  write data; cpu_be  in  2  byte enables; cpu_rw  in  1  (1 read, 0 write).
REQ-006 cpu_req  in  1  toggle request; cpu_ack  out  1  toggle acknowledge; cpu_q  out  16  read data.
REQ-007 scn_addr  in  32  tile-ROM byte address; scn_req  in  1  toggle request; scn_ack  out  1  toggle acknowledge; scn_q  out  32  read data.
REQ-008 sdr_addr  out  ADDR_W; sdr_wdata  out  16; sdr_be  out  2; sdr_rw  out  1; sdr_burst  out  2  (word count); sdr_cmd_valid  out  1; sdr_cmd_ready  in  1.
REQ-009 sdr_rdata  in  16; sdr_rd_valid  in  1  (one pulse per returned word); sdr_wr_done  in  1  (write-complete pulse).

Function
REQ-010 A client SHALL be pending while its req differs from its ack.
REQ-011 The state machine SHALL have the states IDLE, ISSUE, WAIT_RD and WAIT_WR.
REQ-012 In IDLE, when a client is pending, the block SHALL latch that client's command and enter ISSUE on the next edge.
REQ-013 When both clients are pending in IDLE, the CPU SHALL win (fixed priority).
REQ-014 In ISSUE, sdr_cmd_valid SHALL be 1 with stable command fields until the cycle in which sdr_cmd_ready=1.
REQ-015 On that ready cycle the block SHALL go to WAIT_RD for a read or WAIT_WR for a write.
REQ-016 CPU commands SHALL use sdr_burst=1; SCN commands SHALL use sdr_burst=SCN_BURST, sdr_rw=1 and sdr_be=2'b11.
REQ-017 sdr_addr SHALL equal the latched address[ADDR_W-1:0].
REQ-018 In WAIT_RD, rd_valid word k (k starting at 0) SHALL be written to scn_q[16k+15:16k] for SCN, or to cpu_q for CPU.
REQ-019 Unwritten scn_q bits SHALL be 0.
REQ-020 After the final expected word, the owner's ack SHALL toggle on the next edge, simultaneously with the return to IDLE; read data SHALL be stable no later than that ack edge.
REQ-021 In WAIT_WR, sdr_wr_done SHALL toggle cpu_ack on the next edge and return the block to IDLE.
REQ-022 A new arbitration MAY start in the cycle after IDLE is re-entered, giving a minimum of one IDLE cycle between grants.
REQ-023 rd_valid and wr_done pulses in IDLE or ISSUE SHALL be ignored; wr_done in WAIT_RD and rd_valid in WAIT_WR SHALL be ignored.
REQ-024 A req toggle from the owning client while its command is in flight SHALL be ignored until its ack toggles; the re-toggled request is then served as a new request.
REQ-025 cpu_be=2'b00 writes SHALL be issued unchanged.

Reset
REQ-026 While reset_n=0: state=IDLE; cpu_ack=0; scn_ack=0; sdr_cmd_valid=0; cpu_q=0; scn_q=0; all latched command fields 0.
REQ-027 Reset mid-transaction SHALL abandon it with no ack toggle.
REQ-028 After release, a client whose req=1 SHALL be treated as pending.

Configuration
REQ-029 With SDRAM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a simultaneous request the client not granted last wins; the last-granted flag resets to SCN, so CPU wins the first tie.
REQ-030 Without SDRAM_ARB_RR_EN, arbitration SHALL be fixed CPU priority per REQ-013.

Structure
REQ-031 The state enum (arb_state_t) and client-ID enum (CLIENT_CPU, CLIENT_SCN) SHALL live in the shared package sdram_arb_pkg.
REQ-032 A single sub-module, sdram_arb_grant, SHALL contain the pending detection and priority/round-robin selection; everything else stays in sdram_client_arb.

Verification
REQ-033 CPU read at 0x001234; model returns 0xBEEF three cycles after ready -> sdr_addr=0x001234, sdr_burst=1, cpu_q=0xBEEF, cpu_ack toggles exactly once.
REQ-034 SCN read at 0x080000; words 0x1111 then 0x2222 -> sdr_burst=2, scn_q=0x22221111, scn_ack toggles one edge after the second rd_valid.
REQ-035 CPU write 0xA5A5, be=2'b10, with sdr_cmd_ready held low for 5 cycles -> cmd fields stable for all 5 cycles; cpu_ack toggles one edge after wr_done.
REQ-036 CPU and SCN toggle req in the same cycle, repeated 4 times -> without the macro CPU is always granted first; with SDRAM_ARB_RR_EN grants alternate CPU, SCN, CPU, SCN.
REQ-037 reset_n low during WAIT_RD of an SCN read, released with scn_req=1 -> acks read 0, scn_q=0, and the SCN read is re-issued after release.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM client arbiter.
// Holds the FSM state encoding, client IDs and the burst-end helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        WAIT_WR
    } arb_state_t;

    typedef enum logic {
        CLIENT_CPU,
        CLIENT_SCN
    } client_t;

    function automatic logic is_last(logic [1:0] cnt, logic [1:0] burst);
        return (cnt + 2'd1) == burst;
    endfunction

endpackage

// File: rtl/sdram_client_arb_if.sv
// Client and SDRAM command/response bundle for the arbiter.
// master: arbiter view; slave: client/controller environment view.
interface sdram_client_arb_if #(
    parameter int ADDR_W = 27
);
    logic [31:0]       cpu_addr;
    logic [15:0]       cpu_data;
    logic [1:0]        cpu_be;
    logic              cpu_rw;
    logic              cpu_req;
    logic              cpu_ack;
    logic [15:0]       cpu_q;

    logic [31:0]       scn_addr;
    logic              scn_req;
    logic              scn_ack;
    logic [31:0]       scn_q;

    logic [ADDR_W-1:0] sdr_addr;
    logic [15:0]       sdr_wdata;
    logic [1:0]        sdr_be;
    logic              sdr_rw;
    logic [1:0]        sdr_burst;
    logic              sdr_cmd_valid;
    logic              sdr_cmd_ready;
    logic [15:0]       sdr_rdata;
    logic              sdr_rd_valid;
    logic              sdr_wr_done;

    modport master (
        input  cpu_addr, cpu_data, cpu_be, cpu_rw, cpu_req,
        output cpu_ack, cpu_q,
        input  scn_addr, scn_req,
        output scn_ack, scn_q,
        output sdr_addr, sdr_wdata, sdr_be, sdr_rw, sdr_burst, sdr_cmd_valid,
        input  sdr_cmd_ready, sdr_rdata, sdr_rd_valid, sdr_wr_done
    );

    modport slave (
        output cpu_addr, cpu_data, cpu_be, cpu_rw, cpu_req,
        input  cpu_ack, cpu_q,
        output scn_addr, scn_req,
        input  scn_ack, scn_q,
        input  sdr_addr, sdr_wdata, sdr_be, sdr_rw, sdr_burst, sdr_cmd_valid,
        output sdr_cmd_ready, sdr_rdata, sdr_rd_valid, sdr_wr_done
    );

endinterface

// File: rtl/sdram_arb_grant.sv
// Pending detection and client selection for the SDRAM arbiter.
// Define SDRAM_ARB_RR_EN for round-robin ties; default is fixed CPU priority.
module sdram_arb_grant
    import sdram_arb_pkg::*;
(
`ifdef SDRAM_ARB_RR_EN
    input  logic    clk,
    input  logic    reset_n,
    input  logic    take_i,
`endif
    input  logic    cpu_req_i,
    input  logic    cpu_ack_i,
    input  logic    scn_req_i,
    input  logic    scn_ack_i,
    output logic    valid_o,
    output client_t client_o
);

    logic cpu_pend;
    logic scn_pend;

    assign cpu_pend = cpu_req_i ^ cpu_ack_i;
    assign scn_pend = scn_req_i ^ scn_ack_i;
    assign valid_o  = cpu_pend | scn_pend;

`ifdef SDRAM_ARB_RR_EN
    client_t last_q;
    client_t last_d;

    // Reset value SCN lets the CPU win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= CLIENT_SCN;
        else          last_q <= last_d;
    end

    always_comb begin
        last_d   = last_q;
        client_o = CLIENT_CPU;
        if (cpu_pend && scn_pend)
            client_o = (last_q == CLIENT_CPU) ? CLIENT_SCN : CLIENT_CPU;
        else if (scn_pend)
            client_o = CLIENT_SCN;
        if (take_i && valid_o)
            last_d = client_o;
    end
`else
    assign client_o = (!cpu_pend && scn_pend) ? CLIENT_SCN : CLIENT_CPU;
`endif

endmodule

// File: rtl/sdram_client_arb.sv
// Two-client (CPU, tile ROM) toggle-handshake arbiter in front of an SDRAM controller.
// SDRAM_ARB_RR_EN selects round-robin tie breaking in sdram_arb_grant.
module sdram_client_arb
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int SCN_BURST = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    sdram_client_arb_if.master bus
);

    localparam logic [1:0] SCN_BURST_W = SCN_BURST[1:0];

    arb_state_t        state_q, state_d;
    client_t           owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [1:0]        be_q, be_d;
    logic              rw_q, rw_d;
    logic [1:0]        burst_q, burst_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              scn_ack_q, scn_ack_d;
    logic [15:0]       cpu_dq_q, cpu_dq_d;
    logic [31:0]       scn_dq_q, scn_dq_d;

    logic              gnt_valid;
    client_t           gnt_client;

    sdram_arb_grant u_grant (
`ifdef SDRAM_ARB_RR_EN
        .clk       (clk),
        .reset_n   (reset_n),
        .take_i    (state_q == IDLE),
`endif
        .cpu_req_i (bus.cpu_req),
        .cpu_ack_i (cpu_ack_q),
        .scn_req_i (bus.scn_req),
        .scn_ack_i (scn_ack_q),
        .valid_o   (gnt_valid),
        .client_o  (gnt_client)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= CLIENT_CPU;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rw_q      <= 1'b0;
            burst_q   <= '0;
            cnt_q     <= '0;
            cpu_ack_q <= 1'b0;
            scn_ack_q <= 1'b0;
            cpu_dq_q  <= '0;
            scn_dq_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rw_q      <= rw_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            cpu_ack_q <= cpu_ack_d;
            scn_ack_q <= scn_ack_d;
            cpu_dq_q  <= cpu_dq_d;
            scn_dq_q  <= scn_dq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rw_d      = rw_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        cpu_ack_d = cpu_ack_q;
        scn_ack_d = scn_ack_q;
        cpu_dq_d  = cpu_dq_q;
        scn_dq_d  = scn_dq_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_client;
                    cnt_d   = '0;
                    state_d = ISSUE;
                    if (gnt_client == CLIENT_CPU) begin
                        addr_d  = bus.cpu_addr[ADDR_W-1:0];
                        wdata_d = bus.cpu_data;
                        be_d    = bus.cpu_be;
                        rw_d    = bus.cpu_rw;
                        burst_d = 2'd1;
                    end else begin
                        addr_d  = bus.scn_addr[ADDR_W-1:0];
                        wdata_d = '0;
                        be_d    = 2'b11;
                        rw_d    = 1'b1;
                        burst_d = SCN_BURST_W;
                    end
                end
            end
            ISSUE: begin
                if (bus.sdr_cmd_ready)
                    state_d = rw_q ? WAIT_RD : WAIT_WR;
            end
            WAIT_RD: begin
                if (bus.sdr_rd_valid) begin
                    // Word 0 also clears the upper half so short bursts read as zero.
                    if (owner_q == CLIENT_CPU)
                        cpu_dq_d = bus.sdr_rdata;
                    else if (cnt_q == 2'd0)
                        scn_dq_d = {16'h0000, bus.sdr_rdata};
                    else
                        scn_dq_d[31:16] = bus.sdr_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (is_last(cnt_q, burst_q)) begin
                        state_d = IDLE;
                        if (owner_q == CLIENT_CPU) cpu_ack_d = ~cpu_ack_q;
                        else                       scn_ack_d = ~scn_ack_q;
                    end
                end
            end
            WAIT_WR: begin
                if (bus.sdr_wr_done) begin
                    state_d = IDLE;
                    if (owner_q == CLIENT_CPU) cpu_ack_d = ~cpu_ack_q;
                    else                       scn_ack_d = ~scn_ack_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sdr_cmd_valid = (state_q == ISSUE);
    assign bus.sdr_addr      = addr_q;
    assign bus.sdr_wdata     = wdata_q;
    assign bus.sdr_be        = be_q;
    assign bus.sdr_rw        = rw_q;
    assign bus.sdr_burst     = burst_q;
    assign bus.cpu_ack       = cpu_ack_q;
    assign bus.scn_ack       = scn_ack_q;
    assign bus.cpu_q         = cpu_dq_q;
    assign bus.scn_q         = scn_dq_q;

endmodule

// File: tb/tb_sdram_client_arb.sv
// Directed bench for sdram_client_arb: transaction-level model plus per-cycle compare.
// Acts as both clients and as the SDRAM controller.
module tb_sdram_client_arb;

    localparam int AW = 27;

`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    be;
        logic          rw;
        logic [1:0]    burst;
        bit            scn;
    } cmd_t;

    logic clk = 1'b0;
    logic reset_n;

    sdram_client_arb_if #(.ADDR_W(AW)) bus ();

    sdram_client_arb #(.ADDR_W(AW), .SCN_BURST(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cmd_t        expq[$];
    logic        exp_cpu_ack, exp_scn_ack;
    logic [15:0] exp_cpu_q;
    logic [31:0] exp_scn_q;
    bit          last_scn;

    logic [AW-1:0] acc_addr;
    logic [1:0]    acc_burst, acc_be;
    bit            acc_scn;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic cmd_t mk_cpu();
        cmd_t c;
        c.addr  = bus.cpu_addr[AW-1:0];
        c.wdata = bus.cpu_data;
        c.be    = bus.cpu_be;
        c.rw    = bus.cpu_rw;
        c.burst = 2'd1;
        c.scn   = 1'b0;
        return c;
    endfunction

    function automatic cmd_t mk_scn();
        cmd_t c;
        c.addr  = bus.scn_addr[AW-1:0];
        c.wdata = 16'h0;
        c.be    = 2'b11;
        c.rw    = 1'b1;
        c.burst = 2'd2;
        c.scn   = 1'b1;
        return c;
    endfunction

    // Per-cycle compare against the transaction model
    bit          hold = 1'b0;
    logic [AW-1:0] p_addr;
    logic [20:0] p_rest;
    cmd_t        fc;

    always @(negedge clk) begin
        chk("cpu_ack", 32'(bus.cpu_ack), 32'(exp_cpu_ack));
        chk("scn_ack", 32'(bus.scn_ack), 32'(exp_scn_ack));
        chk("cpu_q", 32'(bus.cpu_q), 32'(exp_cpu_q));
        chk("scn_q", bus.scn_q, exp_scn_q);
        if (expq.size() == 0 || !reset_n) begin
            chk("cmd_valid_idle", 32'(bus.sdr_cmd_valid), 32'd0);
        end else if (bus.sdr_cmd_valid) begin
            fc = expq[0];
            chk("cmd_addr", 32'(bus.sdr_addr), 32'(fc.addr));
            chk("cmd_be", 32'(bus.sdr_be), 32'(fc.be));
            chk("cmd_rw", 32'(bus.sdr_rw), 32'(fc.rw));
            chk("cmd_burst", 32'(bus.sdr_burst), 32'(fc.burst));
            if (!fc.rw)
                chk("cmd_wdata", 32'(bus.sdr_wdata), 32'(fc.wdata));
        end
        if (hold) begin
            chk("cmd_hold_valid", 32'(bus.sdr_cmd_valid), 32'd1);
            chk("cmd_hold_addr", 32'(bus.sdr_addr), 32'(p_addr));
            chk("cmd_hold_rest",
                32'({bus.sdr_wdata, bus.sdr_be, bus.sdr_rw, bus.sdr_burst}),
                32'(p_rest));
        end
        hold   = reset_n && bus.sdr_cmd_valid && !bus.sdr_cmd_ready;
        p_addr = bus.sdr_addr;
        p_rest = {bus.sdr_wdata, bus.sdr_be, bus.sdr_rw, bus.sdr_burst};
    end

    // SDRAM controller: accept one command, return data or a write-done pulse.
    task automatic serve(input int rdy_dly, input int lat,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input bit spur, input int limit);
        int   n = 0;
        cmd_t cur;
        while (!bus.sdr_cmd_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.sdr_cmd_valid) begin
            chk("cmd_timeout", 32'(bus.sdr_cmd_valid), 32'd1);
            return;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            bus.sdr_rd_valid = spur;
            bus.sdr_rdata    = 16'hDEAD;
            @(posedge clk); #1;
        end
        bus.sdr_rd_valid  = 1'b0;
        acc_addr          = bus.sdr_addr;
        acc_burst         = bus.sdr_burst;
        acc_be            = bus.sdr_be;
        bus.sdr_cmd_ready = 1'b1;
        @(posedge clk);
        if (expq.size() == 0) begin
            chk("queue_empty", 32'(expq.size()), 32'd1);
            #1 bus.sdr_cmd_ready = 1'b0;
            return;
        end
        cur      = expq.pop_front();
        last_scn = cur.scn;
        acc_scn  = cur.scn;
        #1 bus.sdr_cmd_ready = 1'b0;
        if (cur.rw) begin
            for (int k = 0; k < int'(cur.burst); k++) begin
                if (k >= limit) return;
                for (int i = 0; i < lat - 1; i++) begin
                    bus.sdr_wr_done = spur && i == 0 && k == 0;
                    @(posedge clk); #1;
                end
                bus.sdr_wr_done  = 1'b0;
                bus.sdr_rd_valid = 1'b1;
                bus.sdr_rdata    = (k == 0) ? w0 : w1;
                @(posedge clk);
                if (!cur.scn)    exp_cpu_q = bus.sdr_rdata;
                else if (k == 0) exp_scn_q = {16'h0, bus.sdr_rdata};
                else             exp_scn_q[31:16] = bus.sdr_rdata;
                if (k == int'(cur.burst) - 1) begin
                    if (cur.scn) exp_scn_ack = ~exp_scn_ack;
                    else         exp_cpu_ack = ~exp_cpu_ack;
                end
                #1 bus.sdr_rd_valid = 1'b0;
            end
        end else begin
            for (int i = 0; i < lat - 1; i++) begin
                bus.sdr_rd_valid = spur && i == 0;
                bus.sdr_rdata    = 16'hDEAD;
                @(posedge clk); #1;
            end
            bus.sdr_rd_valid = 1'b0;
            bus.sdr_wr_done  = 1'b1;
            @(posedge clk);
            if (cur.scn) exp_scn_ack = ~exp_scn_ack;
            else         exp_cpu_ack = ~exp_cpu_ack;
            #1 bus.sdr_wr_done = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_cpu_ack = 1'b0;
        exp_scn_ack = 1'b0;
        exp_cpu_q   = 16'h0;
        exp_scn_q   = 32'h0;
        last_scn    = 1'b1;
        expq.delete();
    endtask

    initial begin
        bus.cpu_addr = '0; bus.cpu_data = '0; bus.cpu_be = '0;
        bus.cpu_rw = 1'b0; bus.cpu_req = 1'b0;
        bus.scn_addr = '0; bus.scn_req = 1'b0;
        bus.sdr_cmd_ready = 1'b0; bus.sdr_rdata = '0;
        bus.sdr_rd_valid = 1'b0; bus.sdr_wr_done = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst_scn_q", bus.scn_q, 32'd0);

        // CPU read, data three cycles after ready, stray wr_done in WAIT_RD
        bus.cpu_addr = 32'h0000_1234; bus.cpu_rw = 1'b1; bus.cpu_be = 2'b11;
        expq.push_back(mk_cpu());
        bus.cpu_req = ~bus.cpu_req;
        serve(0, 3, 16'hBEEF, 16'h0, 1'b1, 2);
        chk("t1_addr", 32'(acc_addr), 32'h0000_1234);
        chk("t1_burst", 32'(acc_burst), 32'd1);
        chk("t1_cpu_q", 32'(bus.cpu_q), 32'h0000_BEEF);
        chk("t1_ack", 32'(bus.cpu_ack), 32'd1);

        // SCN two-word read
        bus.scn_addr = 32'h0008_0000;
        expq.push_back(mk_scn());
        bus.scn_req = ~bus.scn_req;
        serve(0, 2, 16'h1111, 16'h2222, 1'b0, 2);
        chk("t2_burst", 32'(acc_burst), 32'd2);
        chk("t2_scn_q", bus.scn_q, 32'h2222_1111);
        chk("t2_ack", 32'(bus.scn_ack), 32'd1);

        // CPU write held in ISSUE for 5 cycles, stray rd_valid in ISSUE/WAIT_WR
        bus.cpu_addr = 32'h0000_2000; bus.cpu_rw = 1'b0;
        bus.cpu_data = 16'hA5A5; bus.cpu_be = 2'b10;
        expq.push_back(mk_cpu());
        bus.cpu_req = ~bus.cpu_req;
        serve(5, 2, 16'h0, 16'h0, 1'b1, 2);
        chk("t3_ack", 32'(bus.cpu_ack), 32'd0);
        chk("t3_cpu_q", 32'(bus.cpu_q), 32'h0000_BEEF);

        // Zero byte-enable write goes out unchanged
        bus.cpu_addr = 32'h0000_3000; bus.cpu_data = 16'h1234; bus.cpu_be = 2'b00;
        expq.push_back(mk_cpu());
        bus.cpu_req = ~bus.cpu_req;
        serve(1, 1, 16'h0, 16'h0, 1'b0, 2);
        chk("t4_be", 32'(acc_be), 32'd0);

        // Stray pulses while IDLE
        bus.sdr_rd_valid = 1'b1; bus.sdr_wr_done = 1'b1; bus.sdr_rdata = 16'hDEAD;
        @(posedge clk); #1;
        bus.sdr_rd_valid = 1'b0; bus.sdr_wr_done = 1'b0;
        @(posedge clk); #1;

        // Re-toggle while in flight is served afterwards as a new request
        bus.cpu_addr = 32'h0000_4000; bus.cpu_rw = 1'b1; bus.cpu_be = 2'b11;
        expq.push_back(mk_cpu());
        bus.cpu_req = ~bus.cpu_req;
        @(posedge clk); #1;
        expq.push_back(mk_cpu());
        bus.cpu_req = ~bus.cpu_req;
        serve(2, 2, 16'h5555, 16'h0, 1'b0, 2);
        serve(0, 1, 16'h6666, 16'h0, 1'b0, 2);
        chk("t5_cpu_q", 32'(bus.cpu_q), 32'h0000_6666);

        // Reset in the middle of an SCN read, scn_req held high
        bus.scn_addr = 32'h0008_0000;
        expq.push_back(mk_scn());
        bus.scn_req = ~bus.scn_req;
        serve(0, 1, 16'h7777, 16'h8888, 1'b0, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        bus.cpu_req = 1'b0;
        bus.scn_req = 1'b1;
        model_reset();
        #2;
        chk("t6_scn_ack", 32'(bus.scn_ack), 32'd0);
        chk("t6_scn_q", bus.scn_q, 32'd0);
        chk("t6_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        @(posedge clk); #1;
        expq.push_back(mk_scn());
        reset_n = 1'b1;
        serve(0, 1, 16'h3333, 16'h4444, 1'b0, 2);
        chk("t6_reissue_addr", 32'(acc_addr), 32'h0008_0000);
        chk("t6_scn_q", bus.scn_q, 32'h4444_3333);
        chk("t6_ack", 32'(bus.scn_ack), 32'd1);

        // Simultaneous requests, four rounds
        for (int r = 0; r < 4; r++) begin
            bit first_scn;
            bus.cpu_addr = 32'h100 + 32'(r);
            bus.scn_addr = 32'h0020_0000 + 32'(r * 16);
            bus.cpu_rw   = 1'b1;
            first_scn = RR && !last_scn;
            if (first_scn) begin
                expq.push_back(mk_scn()); expq.push_back(mk_cpu());
            end else begin
                expq.push_back(mk_cpu()); expq.push_back(mk_scn());
            end
            bus.cpu_req = ~bus.cpu_req;
            bus.scn_req = ~bus.scn_req;
            serve(0, 1, 16'hC000 + 16'(r), 16'hD000 + 16'(r), 1'b0, 2);
            chk("t7_first_grant", 32'(acc_scn), 32'd0);
            serve(0, 1, 16'hE000 + 16'(r), 16'hF000 + 16'(r), 1'b0, 2);
            chk("t7_second_grant", 32'(acc_scn), 32'd1);
        end
        chk("t7_queue_drained", 32'(expq.size()), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
